jnwtr_ckmeas: RTL and testbench



---
 rtl/jnwtr_ckmeas.sv | 132 +++++++++++++
 tb/tb_jnwtr_ckmeas.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/jnwtr_ckmeas.sv
// rtl/jnwtr_ckmeas.sv - counts CKM rising edges over a programmable window of CK cycles
module jnwtr_ckmeas #(
    parameter int WIN_W = 10,
    parameter int CNT_W = 12
) (
    input  logic             CK,
    input  logic             RST,
    inout  wire              AVDD,
    inout  wire              AVSS,
    input  logic             CKM,
    input  logic             START,
    input  logic [WIN_W-1:0] WIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             edge_det;
    logic [WIN_W-1:0] wlen;
    logic [WIN_W-1:0] wcnt;
    logic [CNT_W-1:0] ecnt;
    logic             eovf;

    // Supply pins carry no logic; tie them off into a named sink.
    wire unused_supply = AVDD ^ AVSS;

    // CKM is asynchronous: two flops to resolve metastability, third for edge detect.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= CKM;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 & ~s3;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (START) state_nxt = ST_ARM;
            ST_ARM:  state_nxt = (wlen == '0) ? ST_DONE : ST_MEAS;
            ST_MEAS: if (wcnt == WIN_W'(1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // BUSY comes straight from a flop so it never glitches on state-bit skew.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            BUSY <= 1'b0;
        end else begin
            BUSY <= (state_nxt == ST_ARM) || (state_nxt == ST_MEAS);
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            wlen <= '0;
            wcnt <= '0;
        end else begin
            if (state == ST_IDLE && START) begin
                wlen <= WIN;
            end
            if (state == ST_ARM) begin
                wcnt <= wlen;
            end else if (state == ST_MEAS) begin
                wcnt <= wcnt - WIN_W'(1);
            end
        end
    end

    // Saturating edge counter; an edge seen at full scale only raises the overflow flag.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            ecnt <= '0;
            eovf <= 1'b0;
        end else if (state == ST_ARM) begin
            ecnt <= '0;
            eovf <= 1'b0;
        end else if (state == ST_MEAS && edge_det) begin
            if (ecnt == CNT_MAX) begin
                eovf <= 1'b1;
            end else begin
                ecnt <= ecnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            DONE  <= 1'b0;
            COUNT <= '0;
            OVF   <= 1'b0;
        end else begin
            DONE <= (state == ST_DONE);
            if (state == ST_DONE) begin
                COUNT <= ecnt;
                OVF   <= eovf;
            end
        end
    end

endmodule

// File: tb/tb_jnwtr_ckmeas.sv
// tb/tb_jnwtr_ckmeas.sv - randomized bench for jnwtr_ckmeas against a sample-history model
module tb_jnwtr_ckmeas;

    logic       CK    = 1'b0;
    logic       RST   = 1'b0;
    logic       CKM   = 1'b0;
    logic       START = 1'b0;
    logic [9:0] WIN   = '0;
    wire        avdd;
    wire        avss;
    assign avdd = 1'b1;
    assign avss = 1'b0;

    logic        busy_a, done_a, ovf_a;
    logic [11:0] count_a;
    logic        busy_b, done_b, ovf_b;
    logic [3:0]  count_b;

    jnwtr_ckmeas dut_a (
        .CK(CK), .RST(RST), .AVDD(avdd), .AVSS(avss), .CKM(CKM), .START(START),
        .WIN(WIN), .BUSY(busy_a), .DONE(done_a), .COUNT(count_a), .OVF(ovf_a)
    );

    jnwtr_ckmeas #(.WIN_W(10), .CNT_W(4)) dut_b (
        .CK(CK), .RST(RST), .AVDD(avdd), .AVSS(avss), .CKM(CKM), .START(START),
        .WIN(WIN), .BUSY(busy_b), .DONE(done_b), .COUNT(count_b), .OVF(ovf_b)
    );

    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: CKM value seen at each CK edge, plus the one measurement in flight.
    bit hist [0:65535];
    bit pend = 0;
    int pend_t, pend_w;
    int exp_cnt_a = 0, exp_ovf_a = 0, exp_cnt_b = 0, exp_ovf_b = 0;
    int ck_per = 0, ck_ph = 0;
    bit ck_rand = 0, ck_const = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic bit ckm_val(input int m);
        if (ck_rand) return 1'($urandom_range(0, 1));
        if (ck_per == 0) return ck_const;
        return ((m + ck_ph) % ck_per) < (ck_per / 2);
    endfunction

    function automatic void model_reset(input int n);
        for (int j = n - 2; j <= n; j++) if (j >= 0) hist[j] = 1'b0;
        pend = 0;
        exp_cnt_a = 0; exp_ovf_a = 0; exp_cnt_b = 0; exp_ovf_b = 0;
    endfunction

    // One CK cycle: check the state left by the last edge, then drive the next one.
    task automatic step(input bit st, input int w, input bit rs);
        int n, m, e, exp_done, exp_busy;
        bit c;
        @(negedge CK);
        n = cyc;
        exp_done = 0;
        if (pend && n == pend_t + pend_w + 2) begin
            e = 0;
            for (int j = pend_t; j < pend_t + pend_w; j++)
                if (!hist[j-1] && hist[j]) e++;
            exp_cnt_a = (e > 4095) ? 4095 : e;
            exp_ovf_a = (e > 4095) ? 1 : 0;
            exp_cnt_b = (e > 15) ? 15 : e;
            exp_ovf_b = (e > 15) ? 1 : 0;
            exp_done = 1;
            pend = 0;
        end
        exp_busy = (pend && n >= pend_t && n <= pend_t + pend_w) ? 1 : 0;
        check("done_a", done_a, exp_done);
        check("busy_a", busy_a, exp_busy);
        check("count_a", count_a, exp_cnt_a);
        check("ovf_a", ovf_a, exp_ovf_a);
        check("done_b", done_b, exp_done);
        check("busy_b", busy_b, exp_busy);
        check("count_b", count_b, exp_cnt_b);
        check("ovf_b", ovf_b, exp_ovf_b);
        m = n + 1;
        RST = rs;
        if (rs) model_reset(n);
        START = st;
        WIN = 10'(w);
        c = ckm_val(m);
        CKM = c;
        hist[m] = rs ? 1'b0 : c;
        if (!rs && st && !pend) begin
            pend = 1; pend_t = m; pend_w = w;
        end
    endtask

    task automatic async_reset();
        @(posedge CK);
        #2;
        RST = 1'b1;
        model_reset(cyc);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_count", count_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_count_b", count_b, 0);
    endtask

    task automatic run_meas(input int w, output int ca, output int cb, output int ob, output int lat);
        int t0;
        bit got;
        got = 0; ca = -1; cb = -1; ob = -1; lat = -1;
        step(1, w, 0);
        t0 = cyc + 1;
        for (int i = 0; i < w + 10 && !got; i++) begin
            step(0, $urandom_range(0, 1023), 0);
            if (done_a) begin
                got = 1; lat = cyc - t0;
                ca = count_a; cb = count_b; ob = ovf_b;
            end
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    task automatic set_div(input int p);
        ck_rand = 0; ck_per = p; ck_ph = $urandom_range(0, 19);
    endtask

    function automatic int in_rng(input int v, input int lo, input int hi);
        return (v >= lo && v <= hi) ? 1 : 0;
    endfunction

    int ca, cb, ob, lat, ndone, t0, last_done, w;

    initial begin
        #1 RST = 1'b1;
        set_div(4);
        check("init_busy", busy_a, 0);
        check("init_count", count_a, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(0, 0, 0);

        // Basic measurements
        set_div(4);
        run_meas(100, ca, cb, ob, lat);
        check("lat_100", lat, 102);
        check("cnt_div4_rng", in_rng(ca, 24, 26), 1);
        check("ovf_div4", ovf_a, 0);
        set_div(10);
        run_meas(1000, ca, cb, ob, lat);
        check("lat_1000", lat, 1002);
        check("cnt_div10_rng", in_rng(ca, 99, 101), 1);

        // Static CKM and zero-length window
        ck_rand = 0; ck_per = 0; ck_const = 0;
        run_meas(50, ca, cb, ob, lat);
        check("cnt_static", ca, 0);
        set_div(4);
        run_meas(0, ca, cb, ob, lat);
        check("lat_zero", lat, 2);
        check("cnt_zero", ca, 0);

        // Saturation on the narrow instance
        set_div(3);
        run_meas(100, ca, cb, ob, lat);
        check("sat_cnt_b", cb, 15);
        check("sat_ovf_b", ob, 1);
        check("sat_cnt_a_rng", in_rng(ca, 32, 34), 1);
        set_div(20);
        run_meas(100, ca, cb, ob, lat);
        check("unsat_cnt_b_rng", in_rng(cb, 4, 6), 1);
        check("unsat_ovf_b", ob, 0);

        // START and WIN changes while busy are ignored
        set_div(4);
        ndone = 0; lat = -1;
        step(1, 100, 0);
        t0 = cyc + 1;
        for (int i = 1; i <= 120; i++) begin
            step(i == 10, (i == 10) ? 7 : $urandom_range(0, 1023), 0);
            if (done_a) begin ndone++; lat = cyc - t0; ca = count_a; end
        end
        check("hs_ndone", ndone, 1);
        check("hs_lat", lat, 102);
        check("hs_cnt_rng", in_rng(ca, 24, 26), 1);

        // START held high: back-to-back windows
        ndone = 0; last_done = -1;
        for (int i = 0; i < 320; i++) begin
            step(1, 100, 0);
            if (done_a) begin
                if (last_done >= 0) check("b2b_period", cyc - last_done, 103);
                last_done = cyc; ndone++;
            end
        end
        check("b2b_ndone", ndone, 3);
        for (int i = 0; i < 110; i++) step(0, 0, 0);

        // Reset in the middle of a window
        set_div(4);
        step(1, 100, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 0);
        async_reset();
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        run_meas(20, ca, cb, ob, lat);
        check("rst_lat", lat, 22);
        check("rst_cnt_rng", in_rng(ca, 4, 6), 1);

        // Randomized traffic: random clocks, windows and stray START pulses
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 3) == 0) ck_rand = 1;
            else set_div($urandom_range(2, 24));
            w = $urandom_range(0, 200);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) step(0, 0, 0);
            step(1, w, 0);
            for (int k = 0; k < w + 8; k++)
                step($urandom_range(0, 7) == 0, $urandom_range(0, 255), 0);
            for (int k = 0; k < 300 && pend; k++) step(0, 0, 0);
            if (pend) check("rand_drain", 0, 1);
        end
        step(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
